// File: rtl/display_scan_capture.sv
// Receive-side decoder for a scanned, active-low 7-segment bus: rebuilds the hex number being shown.
// Optional macro DISPLAY_SCAN_CAPTURE_DP_EN also captures the decimal point (bit h) of each digit.
module display_scan_capture #(
   parameter int n_dig         = 4,
   parameter int settle_cycles = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           abcdefgh,
   input  logic [n_dig-1:0]     digit,
   output logic [n_dig*4-1:0]   number,
   output logic [n_dig*4-1:0]   number_frame,
   output logic                 frame_done,
   output logic                 bad_pattern,
   output logic                 bad_strobe,
   output logic [n_dig-1:0]     dp
);

   localparam int CW = $clog2(settle_cycles + 1);
   localparam int IW = (n_dig > 1) ? $clog2(n_dig) : 1;
   localparam logic [CW-1:0] SETTLE_MAX = CW'(settle_cycles);

   logic [7:0]         sSeg_q;
   logic [n_dig-1:0]   sDig_q;
   logic [CW-1:0]      settleCnt_q, settleCnt_d;
   logic               armed_q, armed_d;
   logic [n_dig-1:0]   mask_q, mask_d;
   logic [n_dig*4-1:0] number_q, number_d;
   logic [n_dig*4-1:0] numberFrame_q, numberFrame_d;
   logic               frameDone_q, frameDone_d;
   logic               badPattern_q, badPattern_d;
   logic               badStrobe_q, badStrobe_d;

   logic               inputsSame;
   logic               settleEvent;
   logic               strobeBlank;
   logic               strobeOne;
   logic [IW-1:0]      digIdx;
   logic [4:0]         glyph;

   // Glyph lookup on segments a..g only; h is forced to 1 so it can never influence the decode.
   // Result is {valid, nibble}.
   function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
      logic [4:0] r;
      case ({seg, 1'b1})
         8'h03:   r = 5'h10;
         8'h9F:   r = 5'h11;
         8'h25:   r = 5'h12;
         8'h0D:   r = 5'h13;
         8'h99:   r = 5'h14;
         8'h49:   r = 5'h15;
         8'h41:   r = 5'h16;
         8'h1F:   r = 5'h17;
         8'h01:   r = 5'h18;
         8'h19:   r = 5'h19;
         8'h11:   r = 5'h1A;
         8'hC1:   r = 5'h1B;
         8'h63:   r = 5'h1C;
         8'h85:   r = 5'h1D;
         8'h61:   r = 5'h1E;
         8'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign inputsSame  = (abcdefgh == sSeg_q) && (digit == sDig_q);
   assign strobeBlank = &sDig_q;
   assign strobeOne   = $onehot(~sDig_q);
   assign glyph       = decodeGlyph(sSeg_q[7:1]);

   // The event fires on the edge where the count first reaches its limit, so the result lands
   // settle_cycles+1 edges after the inputs changed; armed keeps it to one event per steady group.
   always_comb begin
      settleCnt_d = '0;
      if (inputsSame) begin
         if (settleCnt_q == SETTLE_MAX) begin
            settleCnt_d = SETTLE_MAX;
         end else begin
            settleCnt_d = settleCnt_q + CW'(1);
         end
      end
   end

   assign settleEvent = armed_q && inputsSame && (settleCnt_d == SETTLE_MAX);

   always_comb begin
      armed_d = armed_q;
      if (!inputsSame) begin
         armed_d = 1'b1;
      end else if (settleEvent) begin
         armed_d = 1'b0;
      end
   end

   always_comb begin
      digIdx = '0;
      for (int i = 0; i < n_dig; i++) begin
         if (!sDig_q[i]) begin
            digIdx = IW'(i);
         end
      end
   end

   // Capture and frame bookkeeping; a frame closes on the capture that fills the mask, and the
   // snapshot includes the digit written on that same edge.
   always_comb begin
      number_d      = number_q;
      numberFrame_d = numberFrame_q;
      mask_d        = mask_q;
      frameDone_d   = 1'b0;
      badPattern_d  = 1'b0;
      badStrobe_d   = 1'b0;
      if (settleEvent && !strobeBlank) begin
         if (!strobeOne) begin
            badStrobe_d = 1'b1;
         end else if (!glyph[4]) begin
            badPattern_d = 1'b1;
         end else begin
            number_d[digIdx*4 +: 4] = glyph[3:0];
            mask_d[digIdx]          = 1'b1;
            if (&mask_d) begin
               frameDone_d   = 1'b1;
               numberFrame_d = number_d;
               mask_d        = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sSeg_q        <= '1;
         sDig_q        <= '1;
         settleCnt_q   <= '0;
         armed_q       <= 1'b1;
         mask_q        <= '0;
         number_q      <= '0;
         numberFrame_q <= '0;
         frameDone_q   <= 1'b0;
         badPattern_q  <= 1'b0;
         badStrobe_q   <= 1'b0;
      end else begin
         sSeg_q        <= abcdefgh;
         sDig_q        <= digit;
         settleCnt_q   <= settleCnt_d;
         armed_q       <= armed_d;
         mask_q        <= mask_d;
         number_q      <= number_d;
         numberFrame_q <= numberFrame_d;
         frameDone_q   <= frameDone_d;
         badPattern_q  <= badPattern_d;
         badStrobe_q   <= badStrobe_d;
      end
   end

`ifdef DISPLAY_SCAN_CAPTURE_DP_EN
   logic [n_dig-1:0] dpLive_q, dpLive_d;

   // h is active-low, so a lit decimal point is stored as 1.
   always_comb begin
      dpLive_d = dpLive_q;
      if (settleEvent && !strobeBlank && strobeOne && glyph[4]) begin
         dpLive_d[digIdx] = ~sSeg_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dpLive_q <= '0;
      end else begin
         dpLive_q <= dpLive_d;
      end
   end

   assign dp = dpLive_q;
`else
   assign dp = '0;
`endif

   assign number       = number_q;
   assign number_frame = numberFrame_q;
   assign frame_done   = frameDone_q;
   assign bad_pattern  = badPattern_q;
   assign bad_strobe   = badStrobe_q;

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: run-length reference model checked every cycle plus directed literal checks.
// Honours DISPLAY_SCAN_CAPTURE_DP_EN the same way as the design.
module tb_display_scan_capture;

   localparam int N = 4;
   localparam int S = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [7:0]     abcdefgh = 8'hFF;
   logic [N-1:0]   digit = '1;
   logic [N*4-1:0] number;
   logic [N*4-1:0] number_frame;
   logic           frame_done;
   logic           bad_pattern;
   logic           bad_strobe;
   logic [N-1:0]   dp;

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int frameCnt = 0;
   int badPatCnt = 0;
   int badStrCnt = 0;
   int frameCycle = 0;
   int phaseStart = 0;

   display_scan_capture #(.n_dig(N), .settle_cycles(S)) dut (
      .clk          (clk),
      .reset        (reset),
      .abcdefgh     (abcdefgh),
      .digit        (digit),
      .number       (number),
      .number_frame (number_frame),
      .frame_done   (frame_done),
      .bad_pattern  (bad_pattern),
      .bad_strobe   (bad_strobe),
      .dp           (dp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference model: an event happens when the raw inputs have been identical for S+1
   // consecutive edges; the edge before the run counts as all-ones right after reset.
   logic [7:0]     glyphTab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                     8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
   logic [7:0]     mPrevSeg = 8'hFF;
   logic [N-1:0]   mPrevDig = '1;
   int             mRun = 0;
   logic [N*4-1:0] mNumber = '0;
   logic [N*4-1:0] mFrame = '0;
   logic [N-1:0]   mMask = '0;
   logic [N-1:0]   mDp = '0;
   bit             mFrameDone = 0;
   bit             mBadPat = 0;
   bit             mBadStr = 0;
   bit             started = 0;

   function automatic int glyphIndex(input logic [7:0] seg);
      logic [7:0] entry;
      for (int i = 0; i < 16; i++) begin
         entry = glyphTab[i];
         if (entry[7:1] == seg[7:1]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int zeros;
      int k;
      int g;
      mFrameDone = 0;
      mBadPat = 0;
      mBadStr = 0;
      if (reset) begin
         started = 1;
         mNumber = '0;
         mFrame = '0;
         mMask = '0;
         mDp = '0;
         mPrevSeg = 8'hFF;
         mPrevDig = '1;
         mRun = 1;
      end else if (started) begin
         if (abcdefgh == mPrevSeg && digit == mPrevDig) begin
            mRun++;
         end else begin
            mRun = 1;
            mPrevSeg = abcdefgh;
            mPrevDig = digit;
         end
         if (mRun == S + 1) begin
            zeros = 0;
            k = 0;
            for (int i = 0; i < N; i++) begin
               if (!digit[i]) begin
                  zeros++;
                  k = i;
               end
            end
            if (zeros > 1) begin
               mBadStr = 1;
            end else if (zeros == 1) begin
               g = glyphIndex(abcdefgh);
               if (g < 0) begin
                  mBadPat = 1;
               end else begin
                  mNumber[k*4 +: 4] = g[3:0];
`ifdef DISPLAY_SCAN_CAPTURE_DP_EN
                  mDp[k] = ~abcdefgh[0];
`endif
                  mMask[k] = 1'b1;
                  if (mMask == '1) begin
                     mFrameDone = 1;
                     mFrame = mNumber;
                     mMask = '0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         checkOutput("number", 32'(number), 32'(mNumber));
         checkOutput("number_frame", 32'(number_frame), 32'(mFrame));
         checkOutput("frame_done", 32'(frame_done), 32'(mFrameDone));
         checkOutput("bad_pattern", 32'(bad_pattern), 32'(mBadPat));
         checkOutput("bad_strobe", 32'(bad_strobe), 32'(mBadStr));
         checkOutput("dp", 32'(dp), 32'(mDp));
         if (frame_done === 1'b1) begin
            frameCnt++;
            frameCycle = cycle;
         end
         if (bad_pattern === 1'b1) badPatCnt++;
         if (bad_strobe === 1'b1) badStrCnt++;
      end
   end

   // Called at a falling edge; holds the pattern for the given number of clock cycles.
   task automatic applyStimulus(input logic [7:0] seg, input logic [N-1:0] dig, input int cycles);
      abcdefgh = seg;
      digit = dig;
      phaseStart = cycle;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyReset();
      reset = 1'b1;
      abcdefgh = 8'hFF;
      digit = '1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [N-1:0] dpExpect;
      @(negedge clk);
      applyReset();

      // Idle blank after reset.
      applyStimulus(8'hFF, 4'hF, 100);
      checkOutput("reset number", 32'(number), 32'h0);
      checkOutput("reset number_frame", 32'(number_frame), 32'h0);
      checkOutput("reset pulses", 32'(frameCnt + badPatCnt + badStrCnt), 32'd0);

      // Full frame 1,2,3,4 on digits 0..3.
      applyStimulus(8'h9F, 4'b1110, 10);
      applyStimulus(8'h25, 4'b1101, 10);
      applyStimulus(8'h0D, 4'b1011, 10);
      applyStimulus(8'h99, 4'b0111, 10);
      checkOutput("frame number", 32'(number), 32'h4321);
      checkOutput("frame snapshot", 32'(number_frame), 32'h4321);
      checkOutput("frame count", 32'(frameCnt), 32'd1);
      checkOutput("frame latency", 32'(frameCycle - phaseStart), 32'(S + 1));

      // Short glitch of 8, then steady 5 on digit 2.
      applyStimulus(8'h01, 4'b1011, 3);
      applyStimulus(8'h49, 4'b1011, 10);
      checkOutput("glitch number", 32'(number), 32'h4521);
      checkOutput("glitch frames", 32'(frameCnt), 32'd1);

      // Illegal glyph on digit 1.
      applyStimulus(8'hFF, 4'b1101, 10);
      checkOutput("bad_pattern count", 32'(badPatCnt), 32'd1);
      checkOutput("bad_pattern number", 32'(number), 32'h4521);

      // Two strobes low at once.
      applyStimulus(8'h03, 4'b1100, 10);
      checkOutput("bad_strobe count", 32'(badStrCnt), 32'd1);
      checkOutput("bad_strobe number", 32'(number), 32'h4521);

      // Partial frame 7,8,9, reset, then full frame A,b,C,d.
      applyStimulus(8'h1F, 4'b1110, 10);
      applyStimulus(8'h01, 4'b1101, 10);
      applyStimulus(8'h19, 4'b1011, 10);
      checkOutput("partial number", 32'(number), 32'h4987);
      checkOutput("partial frames", 32'(frameCnt), 32'd1);
      applyReset();
      checkOutput("midreset number", 32'(number), 32'h0);
      checkOutput("midreset snapshot", 32'(number_frame), 32'h0);
      applyStimulus(8'h11, 4'b1110, 10);
      applyStimulus(8'hC1, 4'b1101, 10);
      applyStimulus(8'h63, 4'b1011, 10);
      checkOutput("post-reset no frame yet", 32'(frameCnt), 32'd1);
      applyStimulus(8'h85, 4'b0111, 10);
      checkOutput("post-reset frames", 32'(frameCnt), 32'd2);
      checkOutput("post-reset snapshot", 32'(number_frame), 32'hDCBA);
      checkOutput("post-reset latency", 32'(frameCycle - phaseStart), 32'(S + 1));

      // Glyph 8 with the decimal point lit on digit 3.
      applyStimulus(8'h00, 4'b0111, 10);
      checkOutput("dp number", 32'(number), 32'h8CBA);
`ifdef DISPLAY_SCAN_CAPTURE_DP_EN
      dpExpect = 4'b1000;
`else
      dpExpect = 4'b0000;
`endif
      checkOutput("dp digit3", 32'(dp), 32'(dpExpect));

      // Glyph 3 with h low on digit 0: still a legal glyph.
      applyStimulus(8'h0C, 4'b1110, 10);
      checkOutput("h ignored number", 32'(number), 32'h8CB3);
      checkOutput("h ignored bad_pattern", 32'(badPatCnt), 32'd1);
`ifdef DISPLAY_SCAN_CAPTURE_DP_EN
      dpExpect = 4'b1001;
`endif
      checkOutput("dp digit0", 32'(dp), 32'(dpExpect));

      applyStimulus(8'hFF, 4'hF, 10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
